// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit and its data-memory interface.
// Holds the RV32I load/store funct3 encodings (stores reuse the LB/LH/LW
// values), byte-enable constants, the top of the data memory, the LSU state
// type and two small request-decode helpers.
package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   localparam logic [31:0] DMEM_TOP_ADDR = 32'h0001_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } lsu_state_e;

   // Stores only exist in signed-looking encodings (SB/SH/SW); unsigned forms are load-only.
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_LB, F3_LH, F3_LW: ok = 1'b1;
         F3_LBU, F3_LHU:      ok = ~we;
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Access size in bytes minus one; also the last byte index of a split access.
   function automatic logic [1:0] size_m1(input logic [2:0] f3);
      logic [1:0] s;
      case (f3[1:0])
         2'b00:   s = 2'd0;
         2'b01:   s = 2'd1;
         2'b10:   s = 2'd3;
         default: s = 2'd0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result extension.
// Ports: raw    - little-endian assembled load data, right-justified
//        funct3 - load funct3 selecting width and signedness
//        result - sign- (LB/LH) or zero- (LBU/LHU) extended value; LW passes through
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   // Select the width and fill bits of the returned value
   always_comb begin
      case (funct3)
         F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
         F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
         F3_LBU:  result = {24'h00_0000, raw[7:0]};
         F3_LHU:  result = {16'h0000, raw[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a byte-addressed, synchronous-read data memory.
// Aligned accesses go out as one memory access; misaligned halfwords/words are
// split into ascending single-byte accesses and reassembled little-endian.
// Ports: clk, rst (async, active-high)
//        req_*  - request handshake from the pipeline (ready only when idle)
//        resp_* - registered one-cycle completion with data/misaligned/error
//        mem_*  - data memory address, write enable/data, byte enables, read data
module load_store_unit
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_misaligned_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_wr_data_o,
   output logic [3:0]  mem_byte_en_o,
   input  logic [31:0] mem_rd_data_i
);

   lsu_state_e  state_r;
   logic        ready_r;
   logic        we_r;
   logic [2:0]  f3_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        split_r;
   logic        err_r;
   logic [1:0]  k_r;
   logic [1:0]  last_k_r;
   logic [31:0] hold_r;

   logic [31:0] mem_addr_r;
   logic        mem_wr_en_r;
   logic [31:0] mem_wr_data_r;
   logic [3:0]  mem_byte_en_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic        resp_mis_r;
   logic        resp_err_r;

   logic [32:0] last_byte_s;
   logic        legal_s;
   logic        split_s;
   logic [1:0]  last_k_s;
   logic [3:0]  be_s;
   logic [1:0]  k_next_s;
   logic [31:0] assembled_s;
   logic [31:0] ext_s;

   // Byte k of the right-justified store data, placed in lane 0 for split writes.
   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   // Decode the presented request: legality, range and split shape
   always_comb begin
      // 33-bit sum so addresses near 2^32 cannot wrap back into range
      last_byte_s = {1'b0, req_addr_i} + {31'b0, size_m1(req_funct3_i)};
      if (funct3_legal(req_we_i, req_funct3_i) && (last_byte_s <= {1'b0, DMEM_TOP_ADDR})) begin
         legal_s = 1'b1;
      end else begin
         legal_s = 1'b0;
      end
      case (req_funct3_i[1:0])
         2'b01: begin
            be_s    = BE_HALF;
            split_s = req_addr_i[0];
         end
         2'b10: begin
            be_s    = BE_WORD;
            split_s = (req_addr_i[1:0] != 2'b00);
         end
         default: begin
            be_s    = BE_BYTE;
            split_s = 1'b0;
         end
      endcase
      if (split_s) begin
         last_k_s = size_m1(req_funct3_i);
      end else begin
         last_k_s = 2'd0;
      end
   end

   // Merge the byte captured this cycle into the holding register
   always_comb begin
      k_next_s    = k_r + 2'd1;
      assembled_s = hold_r;
      if (split_r) begin
         assembled_s[{k_r, 3'b000} +: 8] = mem_rd_data_i[7:0];
      end else begin
         assembled_s = mem_rd_data_i;
      end
   end

   load_extend u_load_extend (
      .raw    (assembled_s),
      .funct3 (f3_r),
      .result (ext_s)
   );

   // Control FSM with registered memory and response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         ready_r       <= 1'b1;
         we_r          <= 1'b0;
         f3_r          <= 3'b000;
         addr_r        <= 32'h0000_0000;
         wdata_r       <= 32'h0000_0000;
         split_r       <= 1'b0;
         err_r         <= 1'b0;
         k_r           <= 2'd0;
         last_k_r      <= 2'd0;
         hold_r        <= 32'h0000_0000;
         mem_addr_r    <= 32'h0000_0000;
         mem_wr_en_r   <= 1'b0;
         mem_wr_data_r <= 32'h0000_0000;
         mem_byte_en_r <= BE_NONE;
         resp_valid_r  <= 1'b0;
         resp_rdata_r  <= 32'h0000_0000;
         resp_mis_r    <= 1'b0;
         resp_err_r    <= 1'b0;
      end else begin
         // Memory strobes and the response pulse last a single cycle unless re-armed below
         resp_valid_r  <= 1'b0;
         mem_wr_en_r   <= 1'b0;
         mem_byte_en_r <= BE_NONE;
         case (state_r)
            ST_IDLE: begin
               if (req_valid_i) begin
                  ready_r  <= 1'b0;
                  we_r     <= req_we_i;
                  f3_r     <= req_funct3_i;
                  addr_r   <= req_addr_i;
                  wdata_r  <= req_wdata_i;
                  split_r  <= split_s;
                  last_k_r <= last_k_s;
                  k_r      <= 2'd0;
                  hold_r   <= 32'h0000_0000;
                  if (legal_s) begin
                     err_r         <= 1'b0;
                     state_r       <= ST_ISSUE;
                     mem_addr_r    <= req_addr_i;
                     mem_wr_en_r   <= req_we_i;
                     mem_byte_en_r <= split_s ? BE_BYTE : be_s;
                     mem_wr_data_r <= split_s ? {24'h00_0000, req_wdata_i[7:0]} : req_wdata_i;
                  end else begin
                     // Rejected requests pass through CAPTURE once without touching memory
                     err_r   <= 1'b1;
                     state_r <= ST_CAPTURE;
                  end
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state_r <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (err_r) begin
                  state_r      <= ST_IDLE;
                  ready_r      <= 1'b1;
                  resp_valid_r <= 1'b1;
                  resp_rdata_r <= 32'h0000_0000;
                  resp_mis_r   <= 1'b0;
                  resp_err_r   <= 1'b1;
               end else if (k_r == last_k_r) begin
                  hold_r       <= assembled_s;
                  state_r      <= ST_IDLE;
                  ready_r      <= 1'b1;
                  resp_valid_r <= 1'b1;
                  resp_rdata_r <= we_r ? 32'h0000_0000 : ext_s;
                  resp_mis_r   <= split_r;
                  resp_err_r   <= 1'b0;
               end else begin
                  hold_r        <= assembled_s;
                  k_r           <= k_next_s;
                  state_r       <= ST_ISSUE;
                  mem_addr_r    <= addr_r + {30'b0, k_next_s};
                  mem_wr_en_r   <= we_r;
                  mem_byte_en_r <= BE_BYTE;
                  mem_wr_data_r <= {24'h00_0000, byte_sel(wdata_r, k_next_s)};
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready_o       = ready_r;
   assign resp_valid_o      = resp_valid_r;
   assign resp_rdata_o      = resp_rdata_r;
   assign resp_misaligned_o = resp_mis_r;
   assign resp_err_o        = resp_err_r;
   assign mem_addr_o        = mem_addr_r;
   assign mem_wr_en_o       = mem_wr_en_r;
   assign mem_wr_data_o     = mem_wr_data_r;
   assign mem_byte_en_o     = mem_byte_en_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-array data memory on the
// mem_* bus, a transaction-level reference model of loads/stores, directed
// cases for the documented scenarios, then randomized requests.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_funct3_i = 3'b000;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_wdata_i = 32'h0;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_misaligned_o;
   logic        resp_err_o;
   logic [31:0] mem_addr_o;
   logic        mem_wr_en_o;
   logic [31:0] mem_wr_data_o;
   logic [3:0]  mem_byte_en_o;
   logic [31:0] mem_rd_data_i;

   load_store_unit dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_we_i          (req_we_i),
      .req_funct3_i      (req_funct3_i),
      .req_addr_i        (req_addr_i),
      .req_wdata_i       (req_wdata_i),
      .resp_valid_o      (resp_valid_o),
      .resp_rdata_o      (resp_rdata_o),
      .resp_misaligned_o (resp_misaligned_o),
      .resp_err_o        (resp_err_o),
      .mem_addr_o        (mem_addr_o),
      .mem_wr_en_o       (mem_wr_en_o),
      .mem_wr_data_o     (mem_wr_data_o),
      .mem_byte_en_o     (mem_byte_en_o),
      .mem_rd_data_i     (mem_rd_data_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- data memory model + access log ----------------
   logic [7:0]  init_mem [0:131071];
   logic [7:0]  dmem     [0:131071];
   bit          written  [0:131071];
   logic [7:0]  ref_mem  [0:131071];
   logic [31:0] rd_q = 32'h0;
   assign mem_rd_data_i = rd_q;

   int          acc_total = 0;
   int          acc_base  = 0;
   logic [3:0]  be_hist   [0:4095];
   logic [31:0] addr_hist [0:4095];
   logic [31:0] wd_hist   [0:4095];
   logic        we_hist   [0:4095];
   int          wr_viol = 0;

   function automatic logic [7:0] mem_byte(input logic [16:0] a);
      return written[a] ? dmem[a] : init_mem[a];
   endfunction

   always @(posedge clk) begin
      if (mem_byte_en_o != 4'b0000) begin
         for (int i = 0; i < 4; i++) begin
            rd_q[8*i +: 8] <= mem_byte(17'(mem_addr_o + 32'(i)));
            if (mem_wr_en_o && mem_byte_en_o[i]) begin
               dmem[17'(mem_addr_o + 32'(i))]    <= mem_wr_data_o[8*i +: 8];
               written[17'(mem_addr_o + 32'(i))] <= 1'b1;
            end
         end
         be_hist[acc_total % 4096]   <= mem_byte_en_o;
         addr_hist[acc_total % 4096] <= mem_addr_o;
         wd_hist[acc_total % 4096]   <= mem_wr_data_o;
         we_hist[acc_total % 4096]   <= mem_wr_en_o;
         acc_total                   <= acc_total + 1;
      end
   end

   always @(negedge clk) begin
      if (mem_byte_en_o == 4'b0000 && mem_wr_en_o) wr_viol <= wr_viol + 1;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } stim_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      logic [3:0]  be;
      int          lat;
      int          nacc;
      int          hs;
   } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   stim_t cur;
   bit    allow_gaps = 1'b0;

   function automatic stim_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      stim_t s;
      s.we = we; s.f3 = f3; s.addr = a; s.wdata = wd;
      return s;
   endfunction

   function automatic exp_t ref_model(input stim_t s, input int hs);
      exp_t        e;
      int          size;
      logic        legal;
      logic [32:0] last;
      logic [31:0] val;
      size  = (s.f3[1:0] == 2'b00) ? 1 : (s.f3[1:0] == 2'b01) ? 2 : (s.f3[1:0] == 2'b10) ? 4 : 0;
      legal = (s.f3 inside {3'b000, 3'b001, 3'b010}) || (!s.we && (s.f3 inside {3'b100, 3'b101}));
      if (legal) begin
         last  = {1'b0, s.addr} + 33'(size - 1);
         legal = (last <= 33'h0_0001_FFFF);
      end
      e.we = s.we; e.addr = s.addr; e.wdata = s.wdata; e.hs = hs;
      e.rdata = 32'h0; e.err = 1'b0; e.mis = 1'b0; e.be = 4'b0000;
      if (!legal) begin
         e.err = 1'b1; e.lat = 2; e.nacc = 0;
      end else begin
         e.mis  = (s.addr % size) != 0;
         e.nacc = e.mis ? size : 1;
         e.lat  = 2 * e.nacc + 1;
         e.be   = e.mis ? 4'b0001 : 4'((1 << size) - 1);
         if (s.we) begin
            for (int i = 0; i < size; i++) ref_mem[17'(s.addr + 32'(i))] = s.wdata[8*i +: 8];
         end else begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | ({24'h0, ref_mem[17'(s.addr + 32'(i))]} << (8 * i));
            if (!s.f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
            e.rdata = val;
         end
      end
      return e;
   endfunction

   // ---------------- driver / scoreboard ----------------
   task automatic drive(input stim_t s);
      req_valid_i  = 1'b1;
      req_we_i     = s.we;
      req_funct3_i = s.f3;
      req_addr_i   = s.addr;
      req_wdata_i  = s.wdata;
   endtask

   task automatic check_resp();
      exp_t        e;
      int          n;
      int          ix;
      logic [31:0] mask;
      logic [31:0] exp_wd;
      if (exp_q.size() == 0) begin
         check_eq("spurious_resp", 32'(resp_valid_o), 32'h0);
         return;
      end
      e = exp_q.pop_front();
      check_eq("latency", 32'(cyc - e.hs), 32'(e.lat));
      check_eq("rdata", resp_rdata_o, e.rdata);
      check_eq("err", 32'(resp_err_o), 32'(e.err));
      check_eq("misaligned", 32'(resp_misaligned_o), 32'(e.mis));
      n = acc_total - acc_base;
      check_eq("access_count", 32'(n), 32'(e.nacc));
      for (int k = 0; k < n && k < e.nacc; k++) begin
         ix = (acc_base + k) % 4096;
         check_eq("acc_be", 32'(be_hist[ix]), 32'(e.be));
         check_eq("acc_addr", addr_hist[ix], e.addr + 32'(k));
         check_eq("acc_we", 32'(we_hist[ix]), 32'(e.we));
         if (e.we) begin
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (be_hist[ix][b]) mask[8*b +: 8] = 8'hFF;
            exp_wd = e.mis ? {24'h0, e.wdata[8*k +: 8]} : e.wdata;
            check_eq("acc_wdata", wd_hist[ix] & mask, exp_wd & mask);
         end
      end
      acc_base = acc_total;
      if (req_valid_i) check_eq("ready_in_resp_cycle", 32'(req_ready_o), 32'h1);
   endtask

   task automatic run_stream();
      int guard;
      bit hs;
      guard = 0;
      while ((stim_q.size() > 0 || exp_q.size() > 0 || req_valid_i) && guard < 4000) begin
         @(negedge clk);
         guard++;
         if (resp_valid_o) check_resp();
         hs = req_valid_i && req_ready_o;
         if (hs) exp_q.push_back(ref_model(cur, cyc));
         @(posedge clk);
         #1;
         if (hs) req_valid_i = 1'b0;
         if (!req_valid_i && stim_q.size() > 0 && (!allow_gaps || $urandom_range(0, 3) != 0)) begin
            cur = stim_q.pop_front();
            drive(cur);
         end
      end
      check_eq("stream_drained", 32'(stim_q.size() + exp_q.size()), 32'h0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_ready"}, 32'(req_ready_o), 32'h1);
      check_eq({pfx, "_resp_valid"}, 32'(resp_valid_o), 32'h0);
      check_eq({pfx, "_resp_rdata"}, resp_rdata_o, 32'h0);
      check_eq({pfx, "_resp_mis"}, 32'(resp_misaligned_o), 32'h0);
      check_eq({pfx, "_resp_err"}, 32'(resp_err_o), 32'h0);
      check_eq({pfx, "_byte_en"}, 32'(mem_byte_en_o), 32'h0);
      check_eq({pfx, "_wr_en"}, 32'(mem_wr_en_o), 32'h0);
      check_eq({pfx, "_addr"}, mem_addr_o, 32'h0);
      check_eq({pfx, "_wdata"}, mem_wr_data_o, 32'h0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int seen;
      int diffs;
      int pick;
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;

      for (int i = 0; i < 131072; i++) begin
         init_mem[i] = 8'($urandom);
         ref_mem[i]  = init_mem[i];
      end
      init_mem[17'h100] = 8'h78; init_mem[17'h101] = 8'h56;
      init_mem[17'h102] = 8'h34; init_mem[17'h103] = 8'h12;
      for (int i = 0; i < 4; i++) ref_mem[17'h100 + 17'(i)] = init_mem[17'h100 + 17'(i)];

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 check_reset_outputs("reset");
      @(negedge clk) rst = 1'b0;

      // Directed cases, issued back-to-back with no gaps
      allow_gaps = 1'b0;
      stim_q.push_back(mk(1'b0, 3'b010, 32'h100, 32'h0));           // LW 0x100 -> 12345678
      stim_q.push_back(mk(1'b1, 3'b000, 32'h101, 32'h0000_0080));   // SB 0x80 @ 0x101
      stim_q.push_back(mk(1'b0, 3'b000, 32'h101, 32'h0));           // LB  -> FFFFFF80
      stim_q.push_back(mk(1'b0, 3'b100, 32'h101, 32'h0));           // LBU -> 00000080
      stim_q.push_back(mk(1'b1, 3'b010, 32'h103, 32'hAABB_CCDD));   // SW split x4
      stim_q.push_back(mk(1'b0, 3'b010, 32'h103, 32'h0));           // LW split readback
      stim_q.push_back(mk(1'b0, 3'b001, 32'h105, 32'h0));           // LH split -> FFFFAABB
      stim_q.push_back(mk(1'b0, 3'b101, 32'h105, 32'h0));           // LHU split
      stim_q.push_back(mk(1'b0, 3'b001, 32'h1FFFF, 32'h0));         // LH out of range
      stim_q.push_back(mk(1'b0, 3'b011, 32'h100, 32'h0));           // illegal funct3
      stim_q.push_back(mk(1'b1, 3'b100, 32'h100, 32'h0));           // store with funct3[2]=1
      stim_q.push_back(mk(1'b0, 3'b010, 32'h1FFFC, 32'h0));         // LW ending at top address
      stim_q.push_back(mk(1'b0, 3'b010, 32'h1FFFD, 32'h0));         // LW one byte past top
      stim_q.push_back(mk(1'b1, 3'b001, 32'h1FFFE, 32'h0000_BEEF)); // SH ending at top address
      run_stream();

      // Reset during the second byte of a split SW
      @(negedge clk);
      cur = mk(1'b1, 3'b010, 32'h103, 32'h5566_7788);
      drive(cur);
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check_eq("rst_pre_byte_en", 32'(mem_byte_en_o), 32'h1);
      check_eq("rst_pre_addr", mem_addr_o, 32'h104);
      rst = 1'b1;
      #1 check_reset_outputs("midop_reset");
      ref_mem[17'h103] = 8'h88;
      @(negedge clk) rst = 1'b0;
      check_eq("midop_access_count", 32'(acc_total - acc_base), 32'h1);
      acc_base = acc_total;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (resp_valid_o) seen++;
      end
      check_eq("midop_no_resp", 32'(seen), 32'h0);
      stim_q.push_back(mk(1'b0, 3'b010, 32'h103, 32'h0));
      stim_q.push_back(mk(1'b0, 3'b010, 32'h104, 32'h0));
      run_stream();

      // Randomized traffic with occasional idle gaps
      allow_gaps = 1'b1;
      for (int i = 0; i < 80; i++) begin
         r_we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            r_f3 = 3'($urandom_range(0, 7));
         end else if (r_we) begin
            r_f3 = 3'($urandom_range(0, 2));
         end else begin
            pick = $urandom_range(0, 4);
            r_f3 = (pick > 2) ? 3'(pick + 1) : 3'(pick);
         end
         if ($urandom_range(0, 5) == 0) r_addr = 32'h1FFF8 + 32'($urandom_range(0, 7));
         else                           r_addr = 32'h100 + 32'($urandom_range(0, 63));
         stim_q.push_back(mk(r_we, r_f3, r_addr, $urandom));
      end
      run_stream();

      check_eq("wr_en_outside_issue", 32'(wr_viol), 32'h0);
      diffs = 0;
      for (int a = 0; a < 512; a++) if (mem_byte(17'(a)) !== ref_mem[a]) diffs++;
      for (int a = 32'h1FF00; a < 131072; a++) if (mem_byte(17'(a)) !== ref_mem[a]) diffs++;
      check_eq("dmem_contents", 32'(diffs), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
